// File: rtl/pipo_wr_arbiter_if.sv
// Write-port bundle for the two-requester PIPO register arbiter.
interface pipo_wr_arbiter_if #(
   parameter int N = 8
);
   logic         hold;
   logic         req0;
   logic [N-1:0] d0;
   logic         req1;
   logic [N-1:0] d1;
   logic         gnt0;
   logic         gnt1;
   logic [N-1:0] Q;
   logic         owner;
   logic         valid;
   logic [3:0]   wr_cnt;

   modport master (
      output hold, req0, d0, req1, d1,
      input  gnt0, gnt1, Q, owner, valid, wr_cnt
   );

   modport slave (
      input  hold, req0, d0, req1, d1,
      output gnt0, gnt1, Q, owner, valid, wr_cnt
   );
endinterface

// File: rtl/pipo_wr_arbiter.sv
// Round-robin arbiter writing one of two requesters into a shared PIPO register.
// One write per two cycles: a grant edge (IDLE->BUSY) followed by a one-cycle BUSY.
module pipo_wr_arbiter #(
   parameter int N = 8
) (
   input logic               clk,
   input logic               n_res,
   pipo_wr_arbiter_if.slave  bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]   state;
   logic [N-1:0] q_reg;
   logic         ptr;
   logic         owner_reg;
   logic         valid_reg;
   logic [3:0]   cnt_reg;
   logic         gnt0_reg;
   logic         gnt1_reg;
   logic         pick1;
   logic         grant;

   // A lone requester wins outright; on contention the pointer decides.
   always_comb begin
      pick1 = bus.req1 & (~bus.req0 | ptr);
      grant = (state == IDLE) & ~bus.hold & (bus.req0 | bus.req1);
   end

   always_ff @(posedge clk) begin
      if (!n_res) begin
         state     <= IDLE;
         q_reg     <= '0;
         ptr       <= 1'b0;
         owner_reg <= 1'b0;
         valid_reg <= 1'b0;
         cnt_reg   <= '0;
         gnt0_reg  <= 1'b0;
         gnt1_reg  <= 1'b0;
      end else begin
         gnt0_reg <= 1'b0;
         gnt1_reg <= 1'b0;
         if (state == BUSY) begin
            state <= IDLE;
         end else if (grant) begin
            state     <= BUSY;
            q_reg     <= pick1 ? bus.d1 : bus.d0;
            gnt0_reg  <= ~pick1;
            gnt1_reg  <= pick1;
            owner_reg <= pick1;
            valid_reg <= 1'b1;
            cnt_reg   <= cnt_reg + 4'd1;
            ptr       <= ~pick1;
         end
      end
   end

   assign bus.Q      = q_reg;
   assign bus.gnt0   = gnt0_reg;
   assign bus.gnt1   = gnt1_reg;
   assign bus.owner  = owner_reg;
   assign bus.valid  = valid_reg;
   assign bus.wr_cnt = cnt_reg;
endmodule

// File: doc/pipo_wr_arbiter.md
PIPO_WR_ARBITER -- requirements
Module: pipo_wr_arbiter

Interface
REQ-001 Parameter N, default 8, register data width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 n_res  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 hold  input  1  freeze: while 1, no new grant and Q retained.
REQ-005 req0  input  1  requester 0 write request, level, held until gnt0.
REQ-006 d0  input  N  requester 0 write data, stable while req0=1.
REQ-007 req1  input  1  requester 1 write request, level, held until gnt1.
REQ-008 d1  input  N  requester 1 write data, stable while req1=1.
REQ-009 gnt0  output  1  registered one-cycle pulse: d0 captured into Q at the preceding edge.
REQ-010 gnt1  output  1  registered one-cycle pulse: d1 captured into Q at the preceding edge.
REQ-011 Q  output  N  shared parallel-in parallel-out register contents.
REQ-012 owner  output  1  index of the last requester written; 0 after reset.
REQ-013 valid  output  1  1 once any write has completed since reset.
REQ-014 wr_cnt  output  4  completed-write count, modulo 16.

Function
REQ-015 Two-state FSM: IDLE and BUSY; state, Q, pointer, owner, valid, wr_cnt, gnt0/gnt1 all registered.
REQ-016 IDLE, hold=0, at least one req: winner chosen, Q <= winner data, gnt_winner <= 1, owner <= winner, valid <= 1, wr_cnt <= wr_cnt+1, state <= BUSY, all at the same edge.
REQ-017 Single requester active: that requester wins regardless of pointer.
REQ-018 Both requesters active: winner = pointer (0 selects req0, 1 selects req1).
REQ-019 After every grant, pointer <= complement of winner index (round-robin).
REQ-020 BUSY lasts exactly one cycle: no grant evaluated, Q held, next edge gnt0=gnt1=0 and state <= IDLE.
REQ-021 Requester samples gnt during BUSY and drops req before the next edge; a req still high on return to IDLE is treated as a new request.
REQ-022 Maximum throughput: one write per two cycles; grant latency from req rise in IDLE to gnt high: 1 edge.
REQ-023 IDLE with hold=1: no grant, Q/pointer/owner/valid/wr_cnt unchanged, state stays IDLE, requests wait.
REQ-024 hold rising during BUSY: the in-flight grant pulse completes normally; hold takes effect from IDLE.
REQ-025 gnt0 and gnt1 never high in the same cycle.
REQ-026 wr_cnt wraps 15 -> 0 with no flag.
REQ-027 No requests in IDLE: all registers hold, gnt0=gnt1=0.

Reset
REQ-028 n_res=0 at a rising edge: Q=0, gnt0=gnt1=0, owner=0, valid=0, wr_cnt=0, pointer=0, state=IDLE.
REQ-029 Reset dominates hold, req0, req1 and any FSM state.
REQ-030 Reset during BUSY: gnt pulse cleared at that edge, no write counted beyond the one already captured, which is discarded (Q=0).
REQ-031 Outputs change on n_res only at a clock edge; no asynchronous path from n_res.

Verification
REQ-032 Reset with req0=1, d0=8'hAA -> after edge Q=8'h00, gnt0=0, valid=0, wr_cnt=0.
REQ-033 req0=1, d0=8'hAA from IDLE -> next edge Q=8'hAA, gnt0=1, owner=0, wr_cnt=1; following edge gnt0=0.
REQ-034 req0 and req1 held high, d0=8'hAA, d1=8'h55, pointer=0 -> grants alternate gnt0, gnt1, gnt0 on cycles 1, 3, 5; Q=8'hAA, 8'h55, 8'hAA.
REQ-035 hold=1, req1=1, d1=8'h55, Q=8'hAA -> 5 cycles no gnt, Q=8'hAA; hold=0 -> next edge Q=8'h55, gnt1=1.
REQ-036 n_res=0 at the edge where gnt1=1 (BUSY) -> next cycle gnt1=0, Q=8'h00, valid=0, state IDLE.
REQ-037 17 single writes from req0 -> wr_cnt reads 1 after the 17th, gnt0 and gnt1 never coincident.
